// File: rtl/game_controller_param.sv
// Ball controller for one- or two-player paddle games.
// Tracks ball position, a gravity arc and wall/paddle reflections, keeps
// per-side scores and runs the serve / point / game-over sequence.
// Handshake-free: hit_* are single-cycle event strobes from the collision
// detectors, rand_en is a one-cycle request answered by rand_ball being valid
// on the following cycle.
module game_controller_param #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int BALL_SIZE   = 20,
    parameter int X_STEP      = 4,
    parameter int GRAV_PERIOD = 4,
    parameter int VY_INIT     = -3,
    parameter int Y_START     = 80,
    parameter int TICK_PP     = 270000,
    parameter int TICK_SOC    = 360000,
    parameter int TICK_BSK    = 520000,
    parameter int FAST_THRESH = 2,
    parameter int SERVE_WAIT  = 1000000,
    parameter int MAX_SCORE   = 7,
    parameter int SCORE_W     = 4
) (
    input  logic               clk_25MHZ,
    input  logic               reset,
    input  logic               upscale,
    input  logic               mode,
    input  logic               game_start,
    input  logic               hit_right,
    input  logic               hit_left,
    input  logic [9:0]         estimated_speed,
    input  logic [1:0]         rand_ball,
    output logic               rand_en,
    output logic [9:0]         ball_x_out,
    output logic [9:0]         ball_y_out,
    output logic               is_ball_moving_left,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RUN   = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [9:0]         r_ball_x;
    logic [9:0]         r_ball_y;
    logic signed [9:0]  r_vy;
    logic               r_dir_left;
    logic [7:0]         r_grav;
    logic [31:0]        r_tick;
    logic [31:0]        r_wait;
    logic [31:0]        r_period;
    logic [SCORE_W-1:0] r_score_left;
    logic [SCORE_W-1:0] r_score_right;
    logic               r_game_over;
    logic               r_rand_en;
    logic               r_mode;
    logic               r_scorer_left;

    logic [9:0]          w_x_lim;
    logic [9:0]          w_y_max;
    logic [31:0]         w_base;
    logic                w_fast;
    logic                w_hit_r;
    logic                w_hit_l;
    logic                w_hit;
    logic                w_step;
    logic                w_edge_l;
    logic                w_edge_r;
    logic                w_start;
    logic                w_serve_done;
    logic                w_serve_load;
    logic                w_grav_wrap;
    logic [7:0]          w_grav_next;
    logic signed [9:0]   w_vy_upd;
    logic signed [11:0]  w_vy_ext;
    logic signed [11:0]  w_y_new;
    logic [SCORE_W-1:0]  w_point_old;
    logic [SCORE_W-1:0]  w_point_new;
    logic                w_point_final;

    // Playfield limits follow the active resolution.
    assign w_x_lim = upscale ? 10'(2 * H_RES - BALL_SIZE) : 10'(H_RES - BALL_SIZE);
    assign w_y_max = upscale ? 10'(2 * V_RES - 1) : 10'(V_RES - 1);

    // Base step period per ball type; type 3 falls back to ping-pong.
    always_comb begin
        w_base = 32'(TICK_PP);
        case (rand_ball)
            2'd1:    w_base = 32'(TICK_SOC);
            2'd2:    w_base = 32'(TICK_BSK);
            default: w_base = 32'(TICK_PP);
        endcase
    end

    assign w_fast = (estimated_speed >= 10'(FAST_THRESH));

    // Hits are only accepted toward the paddle; a hit suppresses the step.
    assign w_hit_r  = (r_state == S_RUN) && hit_right && !r_dir_left;
    assign w_hit_l  = (r_state == S_RUN) && hit_left && r_dir_left && r_mode;
    assign w_hit    = w_hit_r || w_hit_l;
    assign w_step   = (r_state == S_RUN) && !w_hit && (r_tick >= r_period);
    assign w_edge_l = w_step && r_dir_left && (r_ball_x < 10'(X_STEP));
    assign w_edge_r = w_step && !r_dir_left && (r_ball_x >= w_x_lim);

    assign w_start      = game_start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_serve_done = (r_state == S_SERVE) && (r_wait == 32'(SERVE_WAIT - 1));

    // Point bookkeeping: the scorer's new score decides between serve and game over.
    assign w_point_old   = r_scorer_left ? r_score_left : r_score_right;
    assign w_point_new   = (w_point_old >= SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                                : w_point_old + SCORE_W'(1);
    assign w_point_final = (w_point_new == SCORE_W'(MAX_SCORE));
    assign w_serve_load  = w_start || ((r_state == S_POINT) && !w_point_final);

    // Gravity: vy gains +1 on the step where the counter wraps; y uses the old vy.
    assign w_grav_wrap = (r_grav == 8'(GRAV_PERIOD - 1));
    assign w_grav_next = w_grav_wrap ? 8'd0 : r_grav + 8'd1;
    assign w_vy_upd    = r_vy + (w_grav_wrap ? 10'sd1 : 10'sd0);
    assign w_vy_ext    = {{2{r_vy[9]}}, r_vy};
    assign w_y_new     = $signed({2'b00, r_ball_y}) + w_vy_ext;

    // State register.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (game_start) w_state_next = S_SERVE;
            S_SERVE:        if (w_serve_done) w_state_next = S_RUN;
            S_RUN: begin
                if (w_edge_l && r_mode) w_state_next = S_POINT;
                else if (w_edge_r)      w_state_next = r_mode ? S_POINT : S_OVER;
            end
            S_POINT:        w_state_next = w_point_final ? S_OVER : S_SERVE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Ball motion, timers, scores and registered outputs.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_ball_x      <= 10'd100;
            r_ball_y      <= 10'(Y_START);
            r_vy          <= 10'(VY_INIT);
            r_dir_left    <= 1'b1;
            r_grav        <= 8'd0;
            r_tick        <= 32'd0;
            r_wait        <= 32'd0;
            r_period      <= 32'(TICK_PP);
            r_score_left  <= '0;
            r_score_right <= '0;
            r_game_over   <= 1'b0;
            r_rand_en     <= 1'b0;
            r_mode        <= 1'b0;
            r_scorer_left <= 1'b0;
        end else begin
            r_rand_en   <= 1'b0;
            r_game_over <= (w_state_next == S_OVER);
            // rand_ball answers the previous cycle's request.
            if (r_rand_en) r_period <= w_base;

            case (r_state)
                S_IDLE, S_OVER: begin
                    if (game_start) begin
                        r_mode        <= mode;
                        r_score_left  <= '0;
                        r_score_right <= '0;
                        r_dir_left    <= 1'b1;
                    end
                end
                S_SERVE: begin
                    r_wait <= r_wait + 32'd1;
                    r_tick <= 32'd0;
                end
                S_RUN: begin
                    if (w_hit) begin
                        r_dir_left <= w_hit_r;
                        r_tick     <= 32'd0;
                        r_period   <= w_fast ? (w_base >> 1) : w_base;
                        if (w_hit_r && !r_mode && (r_score_right != {SCORE_W{1'b1}}))
                            r_score_right <= r_score_right + SCORE_W'(1);
                    end else if (r_tick < r_period) begin
                        r_tick <= r_tick + 32'd1;
                    end else begin
                        r_tick <= 32'd0;
                        r_grav <= w_grav_next;
                        if (w_y_new <= 12'sd0) begin
                            r_ball_y <= 10'd0;
                            r_vy     <= -w_vy_upd;
                        end else if (w_y_new >= $signed({2'b00, w_y_max})) begin
                            r_ball_y <= w_y_max;
                            r_vy     <= -w_vy_upd;
                        end else begin
                            r_ball_y <= w_y_new[9:0];
                            r_vy     <= w_vy_upd;
                        end
                        if (r_dir_left) begin
                            if (w_edge_l) begin
                                if (!r_mode) begin
                                    r_ball_x   <= 10'd0;
                                    r_dir_left <= 1'b0;
                                    r_rand_en  <= 1'b1;
                                end else begin
                                    r_scorer_left <= 1'b0;
                                end
                            end else begin
                                r_ball_x <= r_ball_x - 10'(X_STEP);
                            end
                        end else begin
                            if (w_edge_r) begin
                                if (r_mode) r_scorer_left <= 1'b1;
                            end else begin
                                r_ball_x <= r_ball_x + 10'(X_STEP);
                            end
                        end
                    end
                end
                S_POINT: begin
                    if (r_scorer_left) r_score_left  <= w_point_new;
                    else               r_score_right <= w_point_new;
                    // Serve toward the side that just conceded.
                    r_dir_left <= !r_scorer_left;
                end
                default: ;
            endcase

            if (w_serve_load) begin
                r_ball_x  <= w_x_lim >> 1;
                r_ball_y  <= 10'(Y_START);
                r_vy      <= 10'(VY_INIT);
                r_grav    <= 8'd0;
                r_wait    <= 32'd0;
                r_rand_en <= 1'b1;
            end
        end
    end

    assign rand_en             = r_rand_en;
    assign ball_x_out          = r_ball_x;
    assign ball_y_out          = r_ball_y;
    assign score_left          = r_score_left;
    assign score_right         = r_score_right;
    assign game_over           = r_game_over;
    assign is_ball_moving_left = r_dir_left && ((r_state == S_SERVE) || (r_state == S_RUN));

endmodule

// File: doc/game_controller_param.md
Name: game_controller_param

Overview:
Parametrised successor to the single-player ball controller. It drives ball position, gravity arc and wall/paddle reflection, and supports two modes selected at game start:
- mode 0: single player; the left wall reflects, the right paddle returns.
- mode 1: two players, a paddle on each side.

It keeps per-side scores and a serve/point/game-over sequence, and sits between the collision detectors, the speed estimator and the random ball-type generator on one side and the renderer on the other.

Parameters:
H_RES, 320, base horizontal resolution; doubled when upscale=1
V_RES, 240, base vertical resolution; doubled when upscale=1
BALL_SIZE, 20, ball width in pixels
X_STEP, 4, horizontal pixels per motion step
GRAV_PERIOD, 4, motion steps per +1 of vertical velocity
VY_INIT, -3, signed initial vertical velocity (pixels/step)
Y_START, 80, serve y position
TICK_PP / TICK_SOC / TICK_BSK, 270000 / 360000 / 520000, clock cycles per step for rand_ball 0 / 1 / 2 (3 -> TICK_PP)
FAST_THRESH, 2, estimated_speed >= this at a hit halves the step period
SERVE_WAIT, 1000000, cycles the ball is held at the serve position
MAX_SCORE, 7, score that ends a two-player game
SCORE_W, 4, score counter width

Ports:
clk_25MHZ  in  1  pixel clock
reset  in  1  asynchronous, active-high
upscale  in  1  1 = 2x resolution limits
mode  in  1  0 = single player, 1 = two player; sampled only on an accepted game_start
game_start  in  1  level; start or restart request
hit_right  in  1  collision with right paddle
hit_left  in  1  collision with left paddle; ignored in mode 0
estimated_speed  in  10  paddle speed at hit
rand_ball  in  2  ball type from random generator
rand_en  out  1  one-cycle request for a new rand_ball
ball_x_out  out  10  ball x
ball_y_out  out  10  ball y
is_ball_moving_left  out  1  dir==left while in SERVE or RUN
score_left  out  SCORE_W  left-side score
score_right  out  SCORE_W  right-side score; hit count in mode 0
game_over  out  1  high in OVER

Behaviour:
Reset (asynchronous) and reset mid-operation force:
- state IDLE, ball_x_out=100, ball_y_out=Y_START, vy=VY_INIT, dir=left.
- All counters 0, period=TICK_PP, scores 0, game_over=0, rand_en=0, mode register 0.

Limits:
- x_lim = (upscale ? 2*H_RES : H_RES) - BALL_SIZE.
- y_max = (upscale ? 2*V_RES : V_RES) - 1.

IDLE and OVER:
- game_start -> latch mode, clear both scores, enter SERVE with dir=left.
- OVER holds game_over=1; it drops the cycle SERVE is entered.

SERVE:
- On entry: ball_x=x_lim>>1, ball_y=Y_START, vy=VY_INIT, gravity count 0, rand_en pulses one cycle.
- The cycle after the pulse, period is loaded from the rand_ball table.
- After SERVE_WAIT cycles -> RUN with tick counter 0.

RUN, each cycle:
- If tick counter < period: increment it.
- Otherwise perform one step and clear the counter:
  - x moves X_STEP in dir.
  - Gravity counter increments; at GRAV_PERIOD-1 it wraps to 0 and vy += 1.
  - y_new = y + vy (old vy), computed signed 12-bit.
  - y_new <= 0: y=0, vy = -(updated vy).
  - y_new >= y_max: y=y_max, vy = -(updated vy).
  - vy is 10-bit signed.

Hits (checked before edges; a hit wins over a same-cycle edge/step):
- hit_right while dir=right: dir=left, tick counter 0; score_right += 1 in mode 0, saturating.
- hit_left while dir=left in mode 1: dir=right, tick counter 0.
- On an accepted hit, period = base(rand type) >> (estimated_speed >= FAST_THRESH).
- A hit while moving away is ignored.

Edges (evaluated at a step):
- dir=left and x < X_STEP:
  - mode 0: x=0, dir=right, rand_en pulse, period reloaded next cycle.
  - mode 1: -> POINT, scorer = right.
- dir=right and x >= x_lim:
  - mode 0: -> OVER.
  - mode 1: -> POINT, scorer = left.

POINT (one cycle):
- Scorer's score += 1, saturating at MAX_SCORE.
- If the new value == MAX_SCORE -> OVER; otherwise -> SERVE with dir toward the player who conceded.

General:
- mode changes outside IDLE/OVER are ignored.
- All outputs are registered except is_ball_moving_left, which is combinational from state/dir.

Test Plan:
1. SERVE_WAIT=2, TICK_PP=3, mode=0, rand_ball=0; pulse game_start -> rand_en one cycle, ball at (150,80) with upscale=0; first step 4 cycles after RUN entry gives x=146, y=77; vy becomes -2 after the 4th step.
2. Mode 0, ball moving left, x reaches < 4 -> x=0, dir right, rand_en pulse; rand_ball=2 gives period TICK_BSK on the next cycle.
3. Mode 0, hit_right with estimated_speed=5 -> dir left, score_right=1, period=TICK_PP>>1; same hit with estimated_speed=1 -> period=TICK_PP. hit_right while dir=left -> no change.
4. Mode 1, left miss with score_right=6, MAX_SCORE=7 -> score_right=7, game_over=1 next cycle; game_start -> scores 0, game_over 0, SERVE.
5. Vertical clamp: y=2, vy=-5 at a step -> y=0, vy=+5 (or +4 if the gravity tick fires); upscale=1, y=475, vy=+6 -> y=479, vy negative.
6. Assert reset mid-RUN -> all outputs at reset values immediately; simultaneous hit_right and right-edge condition -> hit taken, no OVER.
